// File: rtl/fea_node_chain.sv
// fea_node_chain: 1-D chain of NODES signed fixed-point values advanced by
// explicit-Euler diffusion steps, u_i += coef*(u_{i-1} - 2u_i + u_{i+1}).
// One shared multiplier forms coef = dt*kval once per RUN, then updates one
// node per cycle in place. A host loads, reads and runs the chain through a
// valid/ready command port.
// Optional feature: define NODE_CHAIN_PERIODIC_EN to close the chain into a
// ring (node 0 and node NODES-1 become neighbours, endpoints ignored).
module fea_node_chain #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int NODES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               command,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(NODES)-1:0] node_sel,
    input  logic [WIDTH-1:0]         set_val,
    input  logic [WIDTH-1:0]         kval,
    input  logic [WIDTH-1:0]         dt,
    input  logic [WIDTH-1:0]         left_endpt,
    input  logic [WIDTH-1:0]         right_endpt,
    input  logic [15:0]              steps,
    output logic [WIDTH-1:0]         rd_val,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int SEL_W = $clog2(NODES);
    localparam int LW    = WIDTH + 2;   // Laplacian width
    localparam int PW    = LW + WIDTH;  // product width
    localparam int SW    = PW + 1;      // product + node sum width

    localparam logic [SEL_W-1:0]        LAST_IDX = SEL_W'(NODES - 1);
    localparam logic signed [SW-1:0]    SAT_MAX  = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0]    SAT_MIN  = -(SW'(1) <<< (WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE,
        COEF,
        SWEEP,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_SET_NODE = 3'd1,
        CMD_GET_NODE = 3'd2,
        CMD_RUN      = 3'd3,
        CMD_CLEAR    = 3'd4
    } cmd_t;

    state_t state, state_next;

    logic signed [WIDTH-1:0] nodes [NODES];
    logic signed [WIDTH-1:0] dt_q;
    logic signed [WIDTH-1:0] kval_q;
    logic signed [WIDTH-1:0] coef_q;
    logic signed [WIDTH-1:0] old_prev;
`ifdef NODE_CHAIN_PERIODIC_EN
    logic signed [WIDTH-1:0] old_first;
`else
    logic signed [WIDTH-1:0] left_q;
    logic signed [WIDTH-1:0] right_q;
`endif
    logic [15:0]             remaining;
    logic [SEL_W-1:0]        idx;

    logic                    sel_ok;
    logic [SEL_W-1:0]        idx_right;
    logic signed [WIDTH-1:0] u;
    logic signed [WIDTH-1:0] left_n;
    logic signed [WIDTH-1:0] right_n;
    logic signed [LW-1:0]    lap;
    logic signed [LW-1:0]    mul_a;
    logic signed [WIDTH-1:0] mul_b;
    logic signed [PW-1:0]    mul_p;
    logic signed [PW-1:0]    mul_sh;
    logic signed [WIDTH-1:0] coef_new;
    logic signed [WIDTH-1:0] node_new;

    // Clamp a wide signed intermediate into the WIDTH-bit two's complement range.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) begin
            sat = SAT_MAX[WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[WIDTH-1:0];
        end else begin
            sat = v[WIDTH-1:0];
        end
    endfunction

    // Neighbour selection, Laplacian and the shared multiplier (COEF reuses it for dt*kval).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel_ok    = (32'(node_sel) < NODES);
        idx_right = (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
        u         = nodes[idx];

`ifdef NODE_CHAIN_PERIODIC_EN
        // Node NODES-1 has not been rewritten yet when node 0 is updated, so it is still old.
        left_n  = (idx == '0)       ? nodes[NODES-1] : old_prev;
        right_n = (idx == LAST_IDX) ? old_first      : nodes[idx_right];
`else
        left_n  = (idx == '0)       ? left_q  : old_prev;
        right_n = (idx == LAST_IDX) ? right_q : nodes[idx_right];
`endif

        lap = LW'(left_n) + LW'(right_n) - (LW'(u) <<< 1);

        if (state == COEF) begin
            mul_a = LW'(dt_q);
            mul_b = kval_q;
        end else begin
            mul_a = lap;
            mul_b = coef_q;
        end

        mul_p    = PW'(mul_a) * PW'(mul_b);
        mul_sh   = mul_p >>> FRAC;
        coef_new = sat(SW'(mul_sh));
        node_new = sat(SW'(mul_sh) + SW'(u));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && command == CMD_RUN) begin
                    state_next = (steps == 16'd0) ? DONE : COEF;
                end
            end
            COEF: begin
                busy       = 1'b1;
                state_next = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (idx == LAST_IDX && remaining == 16'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Node storage, command execution and sweep bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the node array is a register file that must read back as zero after reset,
            // so every entry is cleared here rather than left to a RAM with undefined contents.
            for (int i = 0; i < NODES; i++) begin
                nodes[i] <= '0;
            end
            dt_q      <= '0;
            kval_q    <= '0;
            coef_q    <= '0;
            old_prev  <= '0;
`ifdef NODE_CHAIN_PERIODIC_EN
            old_first <= '0;
`else
            left_q    <= '0;
            right_q   <= '0;
`endif
            remaining <= '0;
            idx       <= '0;
            rd_val    <= '0;
            rd_valid  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values,
            // which is what lets old_prev and nodes[idx] be updated on the same edge.
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (command)
                            CMD_SET_NODE: begin
                                if (sel_ok) begin
                                    nodes[node_sel] <= set_val;
                                end
                            end
                            CMD_GET_NODE: begin
                                rd_val   <= sel_ok ? nodes[node_sel] : '0;
                                rd_valid <= 1'b1;
                            end
                            CMD_CLEAR: begin
                                for (int i = 0; i < NODES; i++) begin
                                    nodes[i] <= '0;
                                end
                            end
                            CMD_RUN: begin
                                dt_q      <= dt;
                                kval_q    <= kval;
`ifndef NODE_CHAIN_PERIODIC_EN
                                left_q    <= left_endpt;
                                right_q   <= right_endpt;
`endif
                                remaining <= steps;
                                idx       <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                COEF: begin
                    coef_q <= coef_new;
                end
                SWEEP: begin
                    nodes[idx] <= node_new;
                    old_prev   <= u;
`ifdef NODE_CHAIN_PERIODIC_EN
                    if (idx == '0) begin
                        old_first <= u;
                    end
`endif
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        remaining <= remaining - 16'd1;
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fea_node_chain.sv
// Testbench for fea_node_chain (WIDTH=32, FRAC=16, NODES=4): command table,
// read-back scoreboard fed by a behavioural Jacobi model, and hand-written
// sequences for run timing, saturation, busy rejection and mid-run reset.
module tb_fea_node_chain;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int NODES = 4;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_SET = 3'd1;
    localparam logic [2:0] C_GET = 3'd2;
    localparam logic [2:0] C_RUN = 3'd3;
    localparam logic [2:0] C_CLR = 3'd4;

`ifdef NODE_CHAIN_PERIODIC_EN
    localparam bit PERIODIC = 1'b1;
`else
    localparam bit PERIODIC = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [2:0]       command;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       node_sel;
    logic [WIDTH-1:0] set_val;
    logic [WIDTH-1:0] kval;
    logic [WIDTH-1:0] dt;
    logic [WIDTH-1:0] left_endpt;
    logic [WIDTH-1:0] right_endpt;
    logic [15:0]      steps;
    logic [WIDTH-1:0] rd_val;
    logic             rd_valid;
    logic             busy;
    logic             done;

    fea_node_chain #(.WIDTH(WIDTH), .FRAC(FRAC), .NODES(NODES)) dut (
        .clk(clk), .reset(reset), .command(command), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .node_sel(node_sel), .set_val(set_val),
        .kval(kval), .dt(dt), .left_endpt(left_endpt), .right_endpt(right_endpt),
        .steps(steps), .rd_val(rd_val), .rd_valid(rd_valid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0]        exp_q [$];
    logic signed [31:0] m [NODES];

    typedef struct {
        logic [2:0]  cmd;
        logic [1:0]  sel;
        logic [31:0] val;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Every rd_valid pulse consumes one expected value.
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got rd_valid with 0x%08h expected no read", rd_val);
            end else begin
                check("rd_val", rd_val, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [31:0] sat32(input logic signed [95:0] v);
        logic signed [95:0] maxv;
        logic signed [95:0] minv;
        maxv = 96'sd2147483647;
        minv = -maxv - 96'sd1;
        if (v > maxv)      sat32 = 32'h7FFFFFFF;
        else if (v < minv) sat32 = 32'h80000000;
        else               sat32 = v[31:0];
    endfunction

    // Behavioural Jacobi step on a full copy of the previous state.
    task automatic model_run(input logic [15:0] st, input logic signed [31:0] d, input logic signed [31:0] k,
                             input logic signed [31:0] l, input logic signed [31:0] r);
        logic signed [95:0] coef, lap, lft, rgt, u, dd, kk;
        logic signed [31:0] old [NODES];
        dd   = d;
        kk   = k;
        coef = sat32((dd * kk) >>> FRAC);
        for (int s = 0; s < int'(st); s++) begin
            old = m;
            for (int i = 0; i < NODES; i++) begin
                if (i == 0) lft = PERIODIC ? old[NODES-1] : l;
                else        lft = old[i-1];
                if (i == NODES - 1) rgt = PERIODIC ? old[0] : r;
                else                rgt = old[i+1];
                u    = old[i];
                lap  = lft + rgt - 2 * u;
                m[i] = sat32(u + ((coef * lap) >>> FRAC));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [1:0] sel, input logic [31:0] val);
        wait_ready();
        command   = cmd;
        node_sel  = sel;
        set_val   = val;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        command   = C_NOP;
    endtask

    task automatic set_node(input logic [1:0] sel, input logic [31:0] val);
        issue(C_SET, sel, val);
        m[sel] = val;
    endtask

    task automatic clear_all();
        issue(C_CLR, 2'd0, 32'd0);
        for (int i = 0; i < NODES; i++) m[i] = '0;
    endtask

    task automatic get_node(input logic [1:0] sel, input logic [31:0] exp);
        exp_q.push_back(exp);
        issue(C_GET, sel, 32'd0);
    endtask

    task automatic readback_model();
        for (int i = 0; i < NODES; i++) get_node(2'(i), m[i]);
        tick();
    endtask

    // Accepts a RUN at edge E and returns in the cycle after E; inputs are then scrambled.
    task automatic start_run(input logic [15:0] st, input logic [31:0] d, input logic [31:0] k,
                             input logic [31:0] l, input logic [31:0] r);
        wait_ready();
        command     = C_RUN;
        steps       = st;
        dt          = d;
        kval        = k;
        left_endpt  = l;
        right_endpt = r;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid   = 1'b0;
        command     = C_NOP;
        steps       = 16'($urandom);
        dt          = $urandom;
        kval        = $urandom;
        left_endpt  = $urandom;
        right_endpt = $urandom;
    endtask

    // Cycle 1 is the cycle after the accepting edge; returns in the cycle after done.
    task automatic wait_done(output int busy_cnt, output int done_at);
        busy_cnt = 0;
        done_at  = -1;
        for (int c = 1; c <= 200 && done_at < 0; c++) begin
            if (busy) busy_cnt++;
            if (done) done_at = c;
            tick();
        end
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run(input logic [15:0] st, input logic [31:0] d, input logic [31:0] k,
                       input logic [31:0] l, input logic [31:0] r, input string name);
        int bc, da, exp_bc, exp_da;
        start_run(st, d, k, l, r);
        wait_done(bc, da);
        exp_bc = (st == 0) ? 0 : 1 + NODES * int'(st);
        exp_da = (st == 0) ? 1 : 2 + NODES * int'(st);
        check({name, "_done_cycle"}, 32'(da), 32'(exp_da));
        check({name, "_busy_cycles"}, 32'(bc), 32'(exp_bc));
        model_run(st, d, k, l, r);
    endtask

    initial begin
        int bc, da, done_cnt;
        logic [31:0] exp_diff [NODES];

        reset       = 1'b1;
        command     = C_NOP;
        cmd_valid   = 1'b0;
        node_sel    = '0;
        set_val     = '0;
        kval        = '0;
        dt          = '0;
        left_endpt  = '0;
        right_endpt = '0;
        steps       = '0;
        for (int i = 0; i < NODES; i++) m[i] = '0;

        vecs[0]  = '{C_SET, 2'd1, 32'h00010000, 32'h0};
        vecs[1]  = '{C_GET, 2'd1, 32'h0,        32'h00010000};
        vecs[2]  = '{C_SET, 2'd3, 32'hFFFF8000, 32'h0};
        vecs[3]  = '{C_GET, 2'd3, 32'h0,        32'hFFFF8000};
        vecs[4]  = '{C_GET, 2'd0, 32'h0,        32'h0};
        vecs[5]  = '{C_SET, 2'd0, 32'h7FFFFFFF, 32'h0};
        vecs[6]  = '{3'd5,  2'd0, 32'h00001234, 32'h0};
        vecs[7]  = '{C_GET, 2'd0, 32'h0,        32'h7FFFFFFF};
        vecs[8]  = '{3'd7,  2'd1, 32'h00005678, 32'h0};
        vecs[9]  = '{C_CLR, 2'd0, 32'h0,        32'h0};
        vecs[10] = '{C_GET, 2'd3, 32'h0,        32'h0};
        vecs[11] = '{C_GET, 2'd1, 32'h0,        32'h0};

        // Reset state.
        tick();
        tick();
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rd_val", rd_val, 32'd0);
        reset = 1'b0;
        tick();

        // GET right after reset: single-cycle rd_valid in the cycle after accept.
        get_node(2'd2, 32'd0);
        check("get_rd_valid_high", {31'd0, rd_valid}, 32'd1);
        check("get_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        check("get_rd_valid_low", {31'd0, rd_valid}, 32'd0);

        // Command table.
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].cmd == C_GET) begin
                get_node(vecs[v].sel, vecs[v].exp);
            end else begin
                issue(vecs[v].cmd, vecs[v].sel, vecs[v].val);
            end
        end
        tick();
        for (int i = 0; i < NODES; i++) m[i] = '0;

        // Single diffusion step, coef = 0.25.
`ifdef NODE_CHAIN_PERIODIC_EN
        set_node(2'd0, 32'h00010000);
        exp_diff = '{32'h8000, 32'h4000, 32'h0, 32'h4000};
`else
        set_node(2'd1, 32'h00010000);
        exp_diff = '{32'h4000, 32'h8000, 32'h4000, 32'h0};
`endif
        run(16'd1, 32'h8000, 32'h8000, 32'h0, 32'h0, "diff");
        for (int i = 0; i < NODES; i++) get_node(2'(i), exp_diff[i]);
        tick();

        // Three steps with mixed signs and nonzero endpoints.
        set_node(2'd0, 32'h00030000);
        set_node(2'd1, 32'hFFFE0000);
        set_node(2'd2, 32'h00012345);
        set_node(2'd3, 32'h00007000);
        run(16'd3, 32'h6000, 32'h9000, 32'h00020000, 32'hFFFF0000, "multi");
        readback_model();

        // Positive saturation, coef = 1.0.
        clear_all();
        set_node(2'd0, 32'h70000000);
        set_node(2'd1, 32'h7FFF0000);
        run(16'd1, 32'h10000, 32'h10000, 32'h7FFF0000, 32'h0, "satpos");
`ifndef NODE_CHAIN_PERIODIC_EN
        get_node(2'd0, 32'h7FFFFFFF);
`endif
        readback_model();

        // Negative saturation.
        clear_all();
        set_node(2'd0, 32'h90000000);
        set_node(2'd1, 32'h80010000);
        set_node(2'd3, 32'h80000000);
        run(16'd1, 32'h10000, 32'h10000, 32'h80010000, 32'h7FFFFFFF, "satneg");
`ifndef NODE_CHAIN_PERIODIC_EN
        get_node(2'd0, 32'h80000000);
`endif
        readback_model();

        // steps == 0: done in the cycle after accept, nodes unchanged.
        set_node(2'd2, 32'h00045678);
        run(16'd0, 32'h10000, 32'h10000, 32'h0, 32'h0, "zero");
        readback_model();

        // SET_NODE while sweeping is refused and does not write.
        start_run(16'd1, 32'h8000, 32'h8000, 32'h00010000, 32'h0);
        tick();
        check("sweep_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("sweep_busy", {31'd0, busy}, 32'd1);
        command   = C_SET;
        node_sel  = 2'd3;
        set_val   = 32'h0BAD0000;
        cmd_valid = 1'b1;
        tick();
        tick();
        cmd_valid = 1'b0;
        command   = C_NOP;
        wait_done(bc, da);
        check("busy_set_done_seen", {31'd0, da > 0}, 32'd1);
        model_run(16'd1, 32'h8000, 32'h8000, 32'h00010000, 32'h0);
        readback_model();

        // Reset two cycles into a three-step run.
        start_run(16'd3, 32'h8000, 32'h8000, 32'h00010000, 32'h00020000);
        tick();
        reset = 1'b1;
        tick();
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < NODES; i++) m[i] = '0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check("midreset_no_done", 32'(done_cnt), 32'd0);
        readback_model();

        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fea_node_chain.md
# fea_node_chain

Parametrised successor to the single FEA `node`. Holds a 1-D chain of `NODES` signed fixed-point node values and advances them by explicit-Euler diffusion steps, `u_i += coef*(u_{i-1} - 2u_i + u_{i+1})`. It uses one shared multiplier, updating one node per cycle. A host drives it through a command port to load values, read values back and run N steps, which replaces the per-node `SET_NODE` wiring of the first generation.

## Interface
- `WIDTH`, 32, node/coefficient width, signed two's complement
- `FRAC`, 16, fractional bits (Q(WIDTH-FRAC).FRAC)
- `NODES`, 8, chain length, ≥2
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `command` in 3: 0 NOP, 1 SET_NODE, 2 GET_NODE, 3 RUN, 4 CLEAR, 5–7 treated as NOP
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: `state==IDLE`; a command is accepted on an edge where `cmd_valid && cmd_ready`
- `node_sel` in `$clog2(NODES)`: node index for SET/GET
- `set_val` in WIDTH: SET_NODE data
- `kval`, `dt` in WIDTH: sampled at RUN accept
- `left_endpt`, `right_endpt` in WIDTH: fixed boundary values, sampled at RUN accept
- `steps` in 16: iteration count, sampled at RUN accept
- `rd_val` out WIDTH: GET_NODE result
- `rd_valid` out 1: one-cycle pulse with `rd_val`
- `busy` out 1: high in COEF/SWEEP
- `done` out 1: one-cycle pulse at RUN completion

## Operation
- States: IDLE, COEF, SWEEP, DONE.
- IDLE accepts commands:
  - SET_NODE writes `node[node_sel]`.
  - GET_NODE registers `node[node_sel]` into `rd_val` and pulses `rd_valid`.
  - CLEAR zeroes all nodes.
  - RUN latches the inputs and goes to COEF. With `steps==0`, RUN goes straight to DONE.
  - A `node_sel` ≥ NODES makes the write a no-op and the read return 0.
- COEF (1 cycle): `coef = sat((dt*kval) >>> FRAC)`. Uses a 2·WIDTH product and arithmetic shift.
- SWEEP updates one node per cycle, idx 0→NODES-1, in place.
  - An `old_prev` register keeps the pre-update value of node idx-1. The right neighbour is not yet overwritten, so the update is Jacobi-exact.
  - Left neighbour of node 0 is `left_endpt`; right neighbour of node NODES-1 is `right_endpt`.
  - Laplacian is computed in WIDTH+2 bits.
  - New value = `sat(u + ((coef*lap) >>> FRAC))`, clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - At idx NODES-1: decrement `remaining`. If nonzero, idx←0; else go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `cmd_valid` while not ready: ignored, not queued.

## Timing
- Reset values:
  - all nodes 0, state IDLE, `rd_val` 0
  - `rd_valid`/`busy`/`done` 0
  - `cmd_ready` 1 in the cycle after the reset edge
- SET/CLEAR take effect at the accepting edge E.
- GET: `rd_val`/`rd_valid` are valid in the cycle after E.
- RUN accepted at edge E:
  - COEF occupies the cycle after E.
  - Node writes occur on edges E+2 … E+1+steps·NODES.
  - `done` is high in the cycle after the last write.
  - `cmd_ready` rises one cycle later.
- RUN with `steps==0`: `done` high in the cycle after E; nodes unchanged.
- Inputs changing mid-run have no effect, because they were latched at accept.
- Reset mid-run: the next edge clears nodes and state, and `done` is not pulsed.

## Configuration
- `NODE_CHAIN_PERIODIC_EN` defined: periodic ring.
  - Node 0's left neighbour is the old `node[NODES-1]`.
  - Node NODES-1's right neighbour is the old `node[0]`, held in an `old_first` register.
  - `left_endpt`/`right_endpt` are ignored.
- Undefined: fixed boundary endpoints, as above.

## Test plan
All cases use WIDTH=32, FRAC=16, NODES=4.
- Reset, then GET_NODE sel 2 → `rd_val`=0, `rd_valid` pulses one cycle after accept; `cmd_ready`=1.
- SET_NODE sel 1 = 0x00010000, then GET_NODE sel 1 → `rd_val`=0x00010000.
- Diffusion:
  - Setup: nodes {0, 0x10000, 0, 0}, endpoints 0, dt=kval=0x8000 (coef 0x4000), steps=1.
  - Expected result: {0x4000, 0x8000, 0x4000, 0}.
  - `done` is high exactly in the cycle after edge E+5; `busy` is high for 5 cycles.
- Saturation:
  - Setup: node0=0x70000000, node1=0x7FFF0000, left=0x7FFF0000, dt=kval=0x10000, steps=1.
  - Expected: node0=0x7FFFFFFF.
- RUN with steps=0 → `done` in the next cycle, nodes unchanged. SET_NODE during SWEEP → `cmd_ready`=0, no write.
- Reset asserted two cycles into a steps=3 RUN → nodes all 0, `busy`=0, no `done`.
- With `NODE_CHAIN_PERIODIC_EN`:
  - Setup: nodes {0x10000, 0, 0, 0}, coef 0x4000, steps=1.
  - Expected: {0x8000, 0x4000, 0, 0x4000}.
